// File: rtl/el_link_tx_arb_if.sv
// Bundle of the host-side request/grant signals and the dual-rail link port
// shared between the el_link transmit arbiter (slave) and its environment (master).
interface el_link_tx_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int LINK_WIDTH = 2
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*LINK_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            done;
    logic                          err;
    logic                          busy;
    logic [2*LINK_WIDTH-1:0]       link_data;
    logic                          link_ack;

    modport master (
        output req, req_data, link_ack,
        input  grant, done, err, busy, link_data
    );

    modport slave (
        input  req, req_data, link_ack,
        output grant, done, err, busy, link_data
    );
endinterface

// File: rtl/el_link_tx_arb.sv
// Round-robin scheduler that drives one dual-rail el_link input from NUM_REQ
// clocked requesters, running the four-phase RTZ handshake on a synchronized ack.
module el_link_tx_arb #(
    parameter int NUM_REQ     = 4,
    parameter int LINK_WIDTH  = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input logic              clk,
    input logic              rst,
    el_link_tx_arb_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [15:0] TO = 16'(TIMEOUT);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] DATA_WAIT = 2'd1;
    localparam logic [1:0] NULL_WAIT = 2'd2;
    localparam logic [1:0] DONE_ST   = 2'd3;

    logic [1:0]              state;
    logic [PTR_W-1:0]        ptr;
    logic [NUM_REQ-1:0]      grant_r;
    logic [NUM_REQ-1:0]      done_r;
    logic                    err_r;
    logic [2*LINK_WIDTH-1:0] link_data_r;
    logic [15:0]             cnt;
    logic [SYNC_STAGES-1:0]  sync;
    logic                    ack_s;

    logic                    pick_valid;
    logic [PTR_W-1:0]        pick_idx;
    logic [PTR_W-1:0]        cand;
    logic [LINK_WIDTH-1:0]   sel_word;
    logic [2*LINK_WIDTH-1:0] code;

    // link_ack is asynchronous to clk; only the last stage is ever looked at
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.link_ack};
        end
    end

    assign ack_s = sync[SYNC_STAGES-1];

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = PTR_W'((int'(ptr) + off) % NUM_REQ);
            if (!pick_valid && bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Each data bit k becomes rail pair {b, ~b}: 10 for '1', 01 for '0'
    always_comb begin
        sel_word = '0;
        code     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == pick_idx) begin
                sel_word = bus.req_data[i*LINK_WIDTH +: LINK_WIDTH];
            end
        end
        for (int k = 0; k < LINK_WIDTH; k++) begin
            code[2*k+1] = sel_word[k];
            code[2*k]   = ~sel_word[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= PTR_W'(NUM_REQ - 1);
            grant_r     <= '0;
            done_r      <= '0;
            err_r       <= 1'b0;
            link_data_r <= '0;
            cnt         <= '0;
        end else begin
            done_r <= '0;
            err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid && !ack_s) begin
                        grant_r     <= NUM_REQ'(1) << pick_idx;
                        link_data_r <= code;
                        ptr         <= pick_idx;
                        cnt         <= 16'd1;
                        state       <= DATA_WAIT;
                    end
                end
                DATA_WAIT: begin
                    if (ack_s) begin
                        link_data_r <= '0;
                        cnt         <= 16'd1;
                        state       <= NULL_WAIT;
                    end else if (cnt == TO) begin
                        err_r       <= 1'b1;
                        link_data_r <= '0;
                        cnt         <= 16'd1;
                        state       <= NULL_WAIT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                NULL_WAIT: begin
                    // Data cannot be offered while ack is high, so a stuck ack only re-flags err
                    if (!ack_s) begin
                        done_r <= grant_r;
                        state  <= DONE_ST;
                    end else if (cnt == TO) begin
                        err_r <= 1'b1;
                        cnt   <= 16'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE_ST: begin
                    grant_r <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant     = grant_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.busy      = (state != IDLE);
    assign bus.link_data = link_data_r;
endmodule

// File: tb/tb_el_link_tx_arb.sv
// Bench for el_link_tx_arb: vector table, hand-written handshake corner cases
// and randomized transfers checked against a transaction-level round-robin model.
module tb_el_link_tx_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ideal_mode = 1'b1;
    logic ideal_ack  = 1'b0;
    logic forced_ack = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    el_link_tx_arb_if #(.NUM_REQ(4), .LINK_WIDTH(2)) bus ();

    el_link_tx_arb #(
        .NUM_REQ(4), .LINK_WIDTH(2), .SYNC_STAGES(2), .TIMEOUT(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Ideal link: ack follows data/spacer 3 ns after link_data changes
    always begin
        @(bus.link_data);
        #3 ideal_ack = |bus.link_data;
    end

    assign bus.link_ack = ideal_mode ? ideal_ack : forced_ack;

    typedef struct {
        logic [3:0] req;
        logic [7:0] data;
        logic [3:0] exp_grant;
        logic [3:0] exp_link;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [3:0] enc(input logic [1:0] w);
        int v = 0;
        for (int k = 0; k < 2; k++) v += (w[k] ? 2 : 1) << (2 * k);
        return 4'(v);
    endfunction

    function automatic int rr_pick(input logic [3:0] mask, input int p);
        for (int off = 1; off <= 4; off++) begin
            if (mask[(p + off) % 4]) return (p + off) % 4;
        end
        return -1;
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        bus.req = '0;
        ideal_mode = 1'b1;
        forced_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Starts from an IDLE negedge; ends at the negedge after done (IDLE again)
    task automatic apply_stimulus(input logic [3:0] mask, input logic [7:0] data,
                                  input logic [3:0] exp_g, input logic [3:0] exp_ld,
                                  input string tag);
        int n;
        bit seen;
        bus.req = mask;
        bus.req_data = data;
        @(negedge clk);
        n = 1;
        check({tag, "_grant"}, 32'(bus.grant), 32'(exp_g));
        check({tag, "_link_data"}, 32'(bus.link_data), 32'(exp_ld));
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.done != 0) seen = 1;
        end
        check({tag, "_done"}, 32'(bus.done), 32'(exp_g));
        check({tag, "_latency"}, 32'(n), 32'd7);
        check({tag, "_spacer"}, 32'(bus.link_data), 32'd0);
        bus.req = '0;
        @(negedge clk);
        check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic wait_grant(input int max, input string tag);
        int n = 0;
        while (bus.grant == 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (bus.grant == 0) check({tag, "_grant_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int max, input string tag);
        int n = 0;
        while (bus.done == 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (bus.done == 0) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b0001, 8'b00_00_00_10, 4'b0001, 4'b1001};
        vecs[1] = '{4'b1111, 8'b11_10_01_00, 4'b0010, 4'b0110};
        vecs[2] = '{4'b1001, 8'b11_00_00_00, 4'b1000, 4'b1010};
        vecs[3] = '{4'b0110, 8'b00_00_00_00, 4'b0010, 4'b0101};
        vecs[4] = '{4'b0010, 8'b00_00_11_00, 4'b0010, 4'b1010};
        vecs[5] = '{4'b0101, 8'b00_01_00_00, 4'b0100, 4'b0110};
        vecs[6] = '{4'b0011, 8'b00_00_10_01, 4'b0001, 4'b0110};

        bus.req = '0;
        bus.req_data = '0;
        @(negedge clk);
        check("reset_grant", 32'(bus.grant), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_err", {31'd0, bus.err}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_link_data", 32'(bus.link_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i].req, vecs[i].data, vecs[i].exp_grant, vecs[i].exp_link,
                           $sformatf("vec%0d", i));
        end

        // Round-robin fairness with all requests held
        begin
            int prev = -1;
            int idx;
            reset_dut();
            bus.req = 4'b1111;
            bus.req_data = 8'hB4;
            for (int t = 0; t < 8; t++) begin
                wait_grant(20, "rr");
                idx = -1;
                for (int j = 0; j < 4; j++) if (bus.grant[j]) idx = j;
                check($sformatf("rr_grant%0d", t), 32'(bus.grant), 32'(4'b0001 << (t % 4)));
                if (t > 0) check("rr_no_repeat", 32'(idx == prev), 32'd0);
                prev = idx;
                wait_done(40, "rr");
                check($sformatf("rr_done%0d", t), 32'(bus.done), 32'(4'b0001 << (t % 4)));
                @(negedge clk);
            end
            bus.req = '0;
            @(negedge clk);
        end

        // Data timeout: link never acks
        begin
            reset_dut();
            ideal_mode = 1'b0;
            forced_ack = 1'b0;
            bus.req = 4'b0001;
            bus.req_data = 8'h01;
            for (int n = 1; n <= 11; n++) begin
                @(negedge clk);
                if (n == 1) check("to_grant", 32'(bus.grant), 32'd1);
                if (n == 10) check("to_no_early_err", {31'd0, bus.err}, 32'd0);
            end
            check("to_err", {31'd0, bus.err}, 32'd1);
            check("to_spacer", 32'(bus.link_data), 32'd0);
            @(negedge clk);
            check("to_done", 32'(bus.done), 32'd1);
            check("to_err_pulse", {31'd0, bus.err}, 32'd0);
            bus.req = '0;
            @(negedge clk);
            check("to_idle", {31'd0, bus.busy}, 32'd0);
            ideal_mode = 1'b1;
        end

        // Stuck ack in NULL_WAIT, then stale ack in IDLE
        begin
            int errs = 0;
            int e1 = 0;
            int e2 = 0;
            int n;
            reset_dut();
            bus.req = 4'b0001;
            bus.req_data = 8'h02;
            @(negedge clk);
            ideal_mode = 1'b0;
            forced_ack = 1'b1;
            for (n = 2; n <= 28; n++) begin
                @(negedge clk);
                if (bus.err) begin
                    errs++;
                    if (errs == 1) e1 = n;
                    else if (errs == 2) e2 = n;
                end
                if (n == 5) check("stuck_spacer", 32'(bus.link_data), 32'd0);
            end
            check("stuck_err_count", 32'(errs), 32'd2);
            check("stuck_err_first", 32'(e1), 32'd14);
            check("stuck_err_second", 32'(e2), 32'd24);
            forced_ack = 1'b0;
            n = 28;
            while (bus.done == 0 && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("stuck_release_cycle", 32'(n), 32'd31);
            check("stuck_done", 32'(bus.done), 32'd1);
            bus.req = '0;
            @(negedge clk);
            forced_ack = 1'b1;
            repeat (3) @(negedge clk);
            bus.req = 4'b0010;
            bus.req_data = 8'h0C;
            repeat (5) @(negedge clk);
            check("stale_no_grant", 32'(bus.grant), 32'd0);
            check("stale_not_busy", {31'd0, bus.busy}, 32'd0);
            forced_ack = 1'b0;
            ideal_mode = 1'b1;
            wait_grant(20, "stale");
            check("stale_grant", 32'(bus.grant), 32'b0010);
            check("stale_link_data", 32'(bus.link_data), 32'(enc(2'b11)));
            wait_done(40, "stale");
            check("stale_done", 32'(bus.done), 32'b0010);
            bus.req = '0;
            @(negedge clk);
        end

        // Reset mid-transfer
        begin
            reset_dut();
            bus.req = 4'b0001;
            bus.req_data = 8'h03;
            repeat (2) @(negedge clk);
            rst = 1'b1;
            #1;
            check("rstmid_link_data", 32'(bus.link_data), 32'd0);
            check("rstmid_grant", 32'(bus.grant), 32'd0);
            check("rstmid_busy", {31'd0, bus.busy}, 32'd0);
            bus.req = '0;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            apply_stimulus(4'b0100, 8'b00_10_00_00, 4'b0100, enc(2'b10), "rstmid");
        end

        // Requester 1 drops its request while owning the link
        begin
            reset_dut();
            bus.req = 4'b1010;
            bus.req_data = 8'b01_00_10_00;
            @(negedge clk);
            check("drop_grant", 32'(bus.grant), 32'b0010);
            @(negedge clk);
            bus.req = 4'b1000;
            wait_done(40, "drop");
            check("drop_done", 32'(bus.done), 32'b0010);
            @(negedge clk);
            wait_grant(20, "drop_next");
            check("drop_next_grant", 32'(bus.grant), 32'b1000);
            check("drop_next_link", 32'(bus.link_data), 32'(enc(2'b01)));
            wait_done(40, "drop_next");
            bus.req = '0;
            @(negedge clk);
        end

        // Randomized transfers against the round-robin model
        begin
            int ptr_m;
            int pick;
            logic [3:0] mask;
            logic [7:0] data;
            logic [1:0] w;
            reset_dut();
            ptr_m = 3;
            for (int it = 0; it < 30; it++) begin
                mask = 4'($urandom_range(0, 15));
                data = 8'($urandom);
                if (mask == 0) begin
                    bus.req = '0;
                    repeat (3) @(negedge clk);
                    check("rand_idle_grant", 32'(bus.grant), 32'd0);
                end else begin
                    pick = rr_pick(mask, ptr_m);
                    w = 2'((data >> (2 * pick)) & 8'h3);
                    apply_stimulus(mask, data, 4'(1 << pick), enc(w), $sformatf("rand%0d", it));
                    ptr_m = pick;
                end
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
